// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller:
// FSM encoding, combine-mode constants and per-state nibble weights.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic MODE_OR  = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  localparam logic [3:0] WEIGHT_P0 = 4'd0;
  localparam logic [3:0] WEIGHT_P1 = 4'd4;
  localparam logic [3:0] WEIGHT_P2 = 4'd4;
  localparam logic [3:0] WEIGHT_P3 = 4'd8;

  function automatic logic [3:0] state_weight(input state_t s);
    case (s)
      P1:      return WEIGHT_P1;
      P2:      return WEIGHT_P2;
      P3:      return WEIGHT_P3;
      default: return WEIGHT_P0;
    endcase
  endfunction

endpackage

// File: rtl/mult_combine_acc.sv
// Weighted partial-product accumulator: shifts each 4x4 product into place
// and folds it into a 16-bit sum (exact add) or bitwise OR (approximate).
module mult_combine_acc
  import mult_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        mode,
  input  logic [3:0]  shamt,
  input  logic [7:0]  prod,
  output logic [15:0] acc_next
);

  logic [15:0] acc;
  logic [15:0] prod_sh;

  function automatic logic [15:0] combine(input logic [15:0] cur,
                                          input logic [15:0] part,
                                          input logic        m);
    if (m == MODE_ADD) return cur + part;
    else               return cur | part;
  endfunction

  assign prod_sh = {8'd0, prod} << shamt;

  always_comb begin
    acc_next = acc;
    if (clr)     acc_next = '0;
    else if (en) acc_next = combine(acc, prod_sh, mode);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= acc_next;
  end

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier controller driving an external shared 4x4
// multiplier over four cycles, with an optional zero-operand shortcut.
module mult_8x8_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter bit BYPASS_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        mode,
  output logic        mul_en,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic        mul_sel,
  input  logic [7:0]  mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R
);

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        mode_q;
  logic        accept;
  logic        bypass;
  logic [15:0] acc_next;

  assign accept = in_valid && in_ready;
  assign bypass = BYPASS_ZERO && ((A == 8'd0) || (B == 8'd0));

  mult_combine_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (mul_en),
    .mode     (mode_q),
    .shamt    (state_weight(state)),
    .prod     (mul_r),
    .acc_next (acc_next)
  );

  // Multiplier operands are registered one state ahead so they line up with
  // the state in which the product is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      R         <= '0;
      mul_en    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_sel   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= A;
            b_q      <= B;
            mode_q   <= mode;
            in_ready <= 1'b0;
            if (bypass) begin
              state     <= DONE;
              out_valid <= 1'b1;
              R         <= '0;
            end else begin
              state   <= P0;
              mul_en  <= 1'b1;
              mul_a   <= A[3:0];
              mul_b   <= B[3:0];
              mul_sel <= 1'b0;
            end
          end
        end
        P0: begin
          state   <= P1;
          mul_a   <= a_q[3:0];
          mul_b   <= b_q[7:4];
          mul_sel <= 1'b1;
        end
        P1: begin
          state   <= P2;
          mul_a   <= a_q[7:4];
          mul_b   <= b_q[3:0];
          mul_sel <= 1'b1;
        end
        P2: begin
          state   <= P3;
          mul_a   <= a_q[7:4];
          mul_b   <= b_q[7:4];
          mul_sel <= 1'b1;
        end
        P3: begin
          state     <= DONE;
          mul_en    <= 1'b0;
          mul_a     <= '0;
          mul_b     <= '0;
          mul_sel   <= 1'b0;
          out_valid <= 1'b1;
          R         <= acc_next;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            R         <= '0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          R         <= '0;
          mul_en    <= 1'b0;
          mul_a     <= '0;
          mul_b     <= '0;
          mul_sel   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Bench for mult_8x8_seq_ctrl with an ideal external 4x4 multiplier and a
// queue of expected products checked when each result is handed off.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        mode;
  logic        mul_en;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic        mul_sel;
  logic [7:0]  mul_r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] R;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  int          mul_cnt = 0;
  logic [7:0]  sel_seq = 8'd0;
  int          idle_op_err = 0;

  always #5 clk = ~clk;

  assign mul_r = {4'd0, mul_a} * {4'd0, mul_b};

  mult_8x8_seq_ctrl #(.BYPASS_ZERO(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_sel   (mul_sel),
    .mul_r     (mul_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R)
  );

  always @(negedge clk) begin
    if (mul_en) begin
      mul_cnt = mul_cnt + 1;
      sel_seq = {sel_seq[6:0], mul_sel};
    end else if (mul_a != 4'd0 || mul_b != 4'd0 || mul_sel != 1'b0) begin
      idle_op_err = idle_op_err + 1;
    end
  end

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [15:0] p0, p1, p2, p3;
    p0 = 16'(a[3:0]) * 16'(b[3:0]);
    p1 = (16'(a[3:0]) * 16'(b[7:4])) << 4;
    p2 = (16'(a[7:4]) * 16'(b[3:0])) << 4;
    p3 = (16'(a[7:4]) * 16'(b[7:4])) << 8;
    return m ? (p0 + p1 + p2 + p3) : (p0 | p1 | p2 | p3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
    in_valid = 1'b1;
    A = a;
    B = b;
    mode = m;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    mode = 1'($urandom);
  endtask

  // lat = number of rising edges from the accept edge to the edge where out_valid is first seen high
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_result(input string name);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected result queued, R=%h", name, R);
    end else begin
      e = exp_q.pop_front();
      if (R !== e) begin
        bad++;
        $display("FAIL %s: R=%h want %h", name, R, e);
      end
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid: out_valid=%b want 1", name, out_valid);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || R !== 16'h0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: out_valid=%b R=%h in_ready=%b want 0 0000 1",
               name, out_valid, R, in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || R !== 16'h0 || mul_en !== 1'b0 ||
        mul_a !== 4'h0 || mul_b !== 4'h0 || mul_sel !== 1'b0) begin
      bad++;
      $display("FAIL %s: in_ready=%b out_valid=%b R=%h mul_en=%b mul_a=%h mul_b=%h mul_sel=%b want 1 0 0000 0 0 0 0",
               name, in_ready, out_valid, R, mul_en, mul_a, mul_b, mul_sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    step();
    check_reset_outputs("after_reset_idle");
  endtask

  task automatic test_ff_add();
    int lat;
    mul_cnt = 0;
    sel_seq = 8'd0;
    exp_q.push_back(16'hFE01);
    send(8'hFF, 8'hFF, 1'b1);
    wait_valid(lat);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL ff_add_latency: latency=%0d want 5", lat);
    end
    total++;
    if (mul_cnt !== 4) begin
      bad++;
      $display("FAIL ff_add_mul_pulses: pulses=%0d want 4", mul_cnt);
    end
    total++;
    if (sel_seq[3:0] !== 4'b0111) begin
      bad++;
      $display("FAIL ff_add_sel_seq: seq=%b want 0111", sel_seq[3:0]);
    end
    finish_result("ff_add");
  endtask

  task automatic test_ff_or();
    int lat;
    exp_q.push_back(16'hEFF1);
    send(8'hFF, 8'hFF, 1'b0);
    wait_valid(lat);
    finish_result("ff_or");
  endtask

  task automatic test_bypass();
    int lat;
    mul_cnt = 0;
    exp_q.push_back(16'h0000);
    send(8'h00, 8'h5A, 1'b1);
    wait_valid(lat);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL bypass_latency: latency=%0d want 1", lat);
    end
    finish_result("bypass_a0");
    exp_q.push_back(16'h0000);
    send(8'h77, 8'h00, 1'b0);
    wait_valid(lat);
    total++;
    if (lat !== 1 || mul_cnt !== 0) begin
      bad++;
      $display("FAIL bypass_b0: latency=%0d pulses=%0d want 1 0", lat, mul_cnt);
    end
    finish_result("bypass_b0");
  endtask

  task automatic test_hold();
    int lat;
    exp_q.push_back(16'h03A8);
    send(8'h12, 8'h34, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      A = 8'($urandom);
      B = 8'($urandom);
      step();
      total++;
      if (R !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: R=%h out_valid=%b in_ready=%b want 03a8 1 0",
                 i, R, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    finish_result("hold");
  endtask

  task automatic test_reset_mid();
    int lat;
    send(8'hAB, 8'hCD, 1'b1);
    step();
    step();
    total++;
    if (mul_en !== 1'b1 || mul_a !== 4'hA || mul_b !== 4'hD || mul_sel !== 1'b1) begin
      bad++;
      $display("FAIL mid_p2_operands: en=%b a=%h b=%h sel=%b want 1 a d 1",
               mul_en, mul_a, mul_b, mul_sel);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset_async");
    step();
    rst = 1'b0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || mul_en !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_idle: out_valid=%b mul_en=%b in_ready=%b want 0 0 1",
               out_valid, mul_en, in_ready);
    end
    exp_q.push_back(16'h000F);
    send(8'h03, 8'h05, 1'b1);
    wait_valid(lat);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL mid_reset_latency: latency=%0d want 5", lat);
    end
    finish_result("after_mid_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa[2] = '{8'h9C, 8'hA5};
    logic [7:0] pb[2] = '{8'h7E, 8'h3C};
    logic       pm[2] = '{1'b1, 1'b0};
    int n_acc = 0;
    int n_hs = 0;
    int acc_cyc[2] = '{-1, -1};
    int hs_cyc[2] = '{-1, -1};
    logic [15:0] e;
    in_valid = 1'b1;
    A = pa[0];
    B = pb[0];
    mode = pm[0];
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n_hs < 2; c++) begin
      logic acc_ev;
      logic hs_ev;
      acc_ev = in_valid && in_ready;
      hs_ev = out_valid && out_ready;
      if (hs_ev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_result%0d: no expected result queued, R=%h", n_hs, R);
        end else begin
          e = exp_q.pop_front();
          if (R !== e) begin
            bad++;
            $display("FAIL b2b_result%0d: R=%h want %h", n_hs, R, e);
          end
        end
        hs_cyc[n_hs] = c;
        n_hs++;
      end
      if (acc_ev && n_acc < 2) begin
        exp_q.push_back(model(A, B, mode));
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      step();
      if (acc_ev) begin
        if (n_acc == 1) begin
          A = pa[1];
          B = pb[1];
          mode = pm[1];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (n_hs !== 2 || n_acc !== 2) begin
      bad++;
      $display("FAIL b2b_count: handshakes=%0d accepts=%0d want 2 2", n_hs, n_acc);
    end
    total++;
    if (acc_cyc[1] < hs_cyc[0] + 1) begin
      bad++;
      $display("FAIL b2b_spacing: second accept cycle=%0d first handoff cycle=%0d want accept >= handoff+1",
               acc_cyc[1], hs_cyc[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = 8'd0;
    B = 8'd0;
    mode = 1'b0;
    test_reset();
    test_ff_add();
    test_ff_or();
    test_bypass();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (idle_op_err !== 0) begin
      bad++;
      $display("FAIL idle_operands: cycles with nonzero operands while mul_en=0: %0d want 0", idle_op_err);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL leftover_results: queued=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_8x8_seq_ctrl.md
MULT_8X8_SEQ_CTRL -- requirements
Module: mult_8x8_seq_ctrl

Interface
REQ-001 SHALL have parameter BYPASS_ZERO, default 1: when 1, operands with A==0 or B==0 skip the multiplier.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operand request.
REQ-005 SHALL have port in_ready, output, 1 bit: controller can accept operands.
REQ-006 SHALL have port A, input, 8 bits: multiplicand.
REQ-007 SHALL have port B, input, 8 bits: multiplier.
REQ-008 SHALL have port mode, input, 1 bit: 0 = OR combine (approximate), 1 = exact add combine.
REQ-009 SHALL have port mul_en, output, 1 bit: shared 4x4 multiplier operands valid this cycle.
REQ-010 SHALL have port mul_a, output, 4 bits: nibble operand to the shared 4x4 multiplier.
REQ-011 SHALL have port mul_b, output, 4 bits: nibble operand to the shared 4x4 multiplier.
REQ-012 SHALL have port mul_sel, output, 1 bit: variant select; 0 = N1-type (low x low), 1 = R1-type (all other pairs).
REQ-013 SHALL have port mul_r, input, 8 bits: combinational 4x4 product, sampled in the same cycle mul_en is high.
REQ-014 SHALL have port out_valid, output, 1 bit: result valid.
REQ-015 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-016 SHALL have port R, output, 16 bits: product.

Function
REQ-017 SHALL implement FSM states IDLE, P0, P1, P2, P3 and DONE.
REQ-018 SHALL assert in_ready only in IDLE; accept on in_valid&&in_ready and register A, B and mode at accept.
REQ-019 SHALL, after accept, go IDLE->P0->P1->P2->P3->DONE, one cycle per state, with mul_en=1 in P0..P3 only.
REQ-020 SHALL drive these operands: P0 {A[3:0],B[3:0],sel0}; P1 {A[3:0],B[7:4],sel1}; P2 {A[7:4],B[3:0],sel1}; P3 {A[7:4],B[7:4],sel1}.
REQ-021 SHALL, when mul_en=0, drive mul_a, mul_b and mul_sel to 0.
REQ-022 SHALL shift each product by its weight: P0 <<0, P1 <<4, P2 <<4, P3 <<8, each zero-extended to 16 bits.
REQ-023 SHALL, for mode 0, set acc = acc OR shifted product; for mode 1, set acc = acc + shifted product modulo 2^16, with no overflow for 8x8.
REQ-024 SHALL clear the 16-bit accumulator on accept.
REQ-025 SHALL assert out_valid in DONE with R = acc; DONE is first reached 5 cycles after the accept edge.
REQ-026 SHALL hold R and out_valid stable in DONE until out_ready=1, then return to IDLE on the next edge.
REQ-027 SHALL hold R at 0 whenever out_valid=0.
REQ-028 SHALL accept no new request in the same cycle as a DONE handshake; the earliest next accept is one cycle later, in IDLE.
REQ-029 SHALL, with BYPASS_ZERO=1 and a registered zero operand, go IDLE->DONE directly with acc=0 and no mul_en pulses.
REQ-030 SHALL, with BYPASS_ZERO=0, process zero operands through P0..P3 like any other operands.
REQ-031 SHALL ignore in_valid, A, B and mode outside IDLE.

Reset
REQ-032 SHALL, while rst=1 (asynchronously), set the state to IDLE, acc to 0, registered operands to 0 and outputs to in_ready=1, out_valid=0, R=0, mul_en=0, mul_a=0, mul_b=0, mul_sel=0.
REQ-033 SHALL, on reset asserted mid-operation (P0..DONE), discard the pending result; after deassertion the controller waits in IDLE for a new request.

Structure
REQ-034 SHALL take the FSM state encoding, the combine-mode constants and the per-state nibble weight constants from a shared package, mult_ctrl_pkg.
REQ-035 SHALL place the shared 4x4 multiplier outside the block, so any N1/R1 approximate variant can be bound via mul_*; no sub-module inside.
REQ-036 SHALL instantiate one natural sub-module, mult_combine_acc, holding the shift/OR/add accumulator.

Verification (external ideal 4x4 multiplier unless stated)
REQ-037 SHALL check: A=8'hFF, B=8'hFF, mode=1 -> out_valid 5 cycles after accept, R=16'hFE01, exactly 4 mul_en pulses with mul_sel sequence 0,1,1,1.
REQ-038 SHALL check: A=8'hFF, B=8'hFF, mode=0 -> R=16'hEFF1.
REQ-039 SHALL check: A=8'h00, B=8'h5A, BYPASS_ZERO=1 -> out_valid 1 cycle after accept, R=0, mul_en never high.
REQ-040 SHALL check: A=8'h12, B=8'h34, mode=1, out_ready held low for 3 cycles -> R=16'h03A8 stable, in_ready=0 throughout, IDLE on the cycle after out_ready rises.
REQ-041 SHALL check: rst asserted during P2 -> outputs at reset values immediately; next request A=3, B=5, mode=1 -> R=16'h000F.
REQ-042 SHALL check: in_valid held high across two back-to-back operand pairs -> second accept no earlier than one cycle after the first DONE handshake; both results correct.
